elevator_dispatch: RTL and testbench

Car-side controller for the 4-floor elevator: latches hall and car calls, moves the car floor-by-floor with a collective up/down sweep, and drives the door block. It is the initiator of the door handshake. It raises `Door` to request opening, holds it for a dwell time, then drops it and waits for the door block's `DoorClose` before moving. It runs on the 1 kHz system clock alongside the door block and the floor display.

---
 rtl/elevator_pkg.sv | 71 +++++++
 rtl/elevator_dispatch_ms_timer.sv | 30 +++
 rtl/elevator_dispatch.sv | 200 ++++++++++++++++++++
 tb/tb_elevator_dispatch.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : elevator_pkg
// Purpose  : Shared types, call-lamp bit positions and call-map helpers for
//            the 4-floor elevator car controller.
// Revision : 1.0 - initial release
// ============================================================================
package elevator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_MOVE       = 3'd1,
    ST_OPEN_WAIT  = 3'd2,
    ST_DWELL      = 3'd3,
    ST_CLOSE_WAIT = 3'd4
  } state_t;

  // Call lamp bit positions: {B4,B3,B2,B1,B4D,B3D,B3U,B2D,B2U,B1U}
  localparam int REQ_B1U = 0;
  localparam int REQ_B2U = 1;
  localparam int REQ_B2D = 2;
  localparam int REQ_B3U = 3;
  localparam int REQ_B3D = 4;
  localparam int REQ_B4D = 5;
  localparam int REQ_B1  = 6;
  localparam int REQ_B2  = 7;
  localparam int REQ_B3  = 8;
  localparam int REQ_B4  = 9;
  localparam int NUM_REQ = 10;

  localparam int FLOOR_W    = 2;
  localparam int NUM_FLOORS = 4;
  localparam int TIMER_W    = 16;

  // Per-floor views of the call register (bit n = floor n).
  function automatic logic [NUM_FLOORS-1:0] car_calls(input logic [NUM_REQ-1:0] req);
    return {req[REQ_B4], req[REQ_B3], req[REQ_B2], req[REQ_B1]};
  endfunction

  function automatic logic [NUM_FLOORS-1:0] up_calls(input logic [NUM_REQ-1:0] req);
    return {1'b0, req[REQ_B3U], req[REQ_B2U], req[REQ_B1U]};
  endfunction

  function automatic logic [NUM_FLOORS-1:0] dn_calls(input logic [NUM_REQ-1:0] req);
    return {req[REQ_B4D], req[REQ_B3D], req[REQ_B2D], 1'b0};
  endfunction

  // Any call strictly beyond floor f in the given direction.
  function automatic logic calls_ahead(input logic [NUM_FLOORS-1:0] any,
                                       input logic [FLOOR_W-1:0] f,
                                       input logic up);
    if (up) return |(any & (4'b1110 << f));
    else    return |(any & (4'b0111 >> (2'd3 - f)));
  endfunction

  // Bits to clear when serving floor f heading in direction up; both also
  // clears the opposite hall call (nothing left to serve further on).
  function automatic logic [NUM_REQ-1:0] serve_mask(input logic [FLOOR_W-1:0] f,
                                                    input logic up,
                                                    input logic both);
    logic [3:0] oh;
    logic [2:0] cu;
    logic [2:0] cd;
    oh = 4'b0001 << f;
    cu = (up || both) ? oh[2:0] : 3'b000;   // up hall calls live on floors 0..2
    cd = (!up || both) ? oh[3:1] : 3'b000;  // down hall calls live on floors 1..3
    return {oh, cd[2], cd[1], cu[2], cd[0], cu[1], cu[0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/elevator_dispatch_ms_timer.sv
`default_nettype none
// ============================================================================
// Module   : ms_timer
// Purpose  : Loadable down-counter; done is high while the count sits at 1,
//            i.e. on the edge where it reaches 0. A load on that edge wins.
// Revision : 1.0 - initial release
// ============================================================================
module ms_timer #(
  parameter int W = 16
) (
  input  logic         clk_1khz,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  // Count down to zero and park there until the next load.
  always_ff @(posedge clk_1khz) begin
    if (rst)                count <= '0;
    else if (load)          count <= load_val;
    else if (count != '0)   count <= count - W'(1);
  end

  assign done = (count == W'(1));

endmodule
`default_nettype wire

// File: rtl/elevator_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : elevator_dispatch
// Purpose  : Car-side controller: latches hall/car calls, runs a collective
//            up/down sweep floor by floor and initiates the door handshake.
// Revision : 1.0 - initial release
// ============================================================================
module elevator_dispatch
  import elevator_pkg::*;
#(
  parameter int MOVE_MS     = 2000,
  parameter int DWELL_MS    = 3000,
  parameter int CLOSE_TO_MS = 1500
) (
  input  logic               clk_1khz,
  input  logic               rst,
  input  logic               B1U,
  input  logic               B2U,
  input  logic               B2D,
  input  logic               B3U,
  input  logic               B3D,
  input  logic               B4D,
  input  logic               B1,
  input  logic               B2,
  input  logic               B3,
  input  logic               B4,
  input  logic               DoorClose,
  output logic               Door,
  output logic [FLOOR_W-1:0] Floor,
  output logic               Up,
  output logic               Down,
  output logic [NUM_REQ-1:0] Req,
  output logic               Fault
);

  localparam logic [TIMER_W-1:0] MOVE_TICKS  = TIMER_W'(MOVE_MS);
  localparam logic [TIMER_W-1:0] DWELL_TICKS = TIMER_W'(DWELL_MS);
  localparam logic [TIMER_W-1:0] CLOSE_TICKS = TIMER_W'(CLOSE_TO_MS);

  logic [NUM_REQ-1:0]    btn_raw, btn_s1, btn_s2, clr;
  logic                  dc_s1, dc_s2;
  state_t                state, state_nxt;
  logic                  dir, dir_nxt;          // 1 = up
  logic [FLOOR_W-1:0]    floor_nxt;
  logic                  door_nxt, up_nxt, down_nxt, fault_nxt;
  logic                  serve, keep;
  logic                  tmr_load, tmr_done;
  logic [TIMER_W-1:0]    tmr_val;
  logic [NUM_FLOORS-1:0] car_v, up_v, dn_v, any_v;

  assign btn_raw = {B4, B3, B2, B1, B4D, B3D, B3U, B2D, B2U, B1U};
  assign car_v   = car_calls(Req);
  assign up_v    = up_calls(Req);
  assign dn_v    = dn_calls(Req);
  assign any_v   = car_v | up_v | dn_v;

  ms_timer #(.W(TIMER_W)) u_timer (
    .clk_1khz (clk_1khz),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Two-flop synchronizers for the asynchronous buttons and door status.
  always_ff @(posedge clk_1khz) begin
    if (rst) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
      dc_s1  <= 1'b0;
      dc_s2  <= 1'b0;
    end else begin
      btn_s1 <= btn_raw;
      btn_s2 <= btn_s1;
      dc_s1  <= DoorClose;
      dc_s2  <= dc_s1;
    end
  end

  // Call latch: a live button beats a simultaneous clear.
  always_ff @(posedge clk_1khz) begin
    if (rst) Req <= '0;
    else     Req <= (Req & ~clr) | btn_s2;
  end

  // State, direction and registered outputs.
  always_ff @(posedge clk_1khz) begin
    if (rst) begin
      state <= ST_IDLE;
      dir   <= 1'b1;
      Floor <= '0;
      Door  <= 1'b0;
      Up    <= 1'b0;
      Down  <= 1'b0;
      Fault <= 1'b0;
    end else begin
      state <= state_nxt;
      dir   <= dir_nxt;
      Floor <= floor_nxt;
      Door  <= door_nxt;
      Up    <= up_nxt;
      Down  <= down_nxt;
      Fault <= fault_nxt;
    end
  end

  // Next-state, sweep decisions, call serving and next output values.
  always_comb begin
    state_nxt = state;
    dir_nxt   = dir;
    floor_nxt = Floor;
    fault_nxt = Fault;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    serve     = 1'b0;
    keep      = 1'b0;
    clr       = '0;

    case (state)
      ST_IDLE: begin
        if (any_v[Floor]) begin
          serve     = 1'b1;
          state_nxt = ST_OPEN_WAIT;
        end else if (dc_s2 && calls_ahead(any_v, Floor, dir)) begin
          state_nxt = ST_MOVE;
          tmr_load  = 1'b1;
          tmr_val   = MOVE_TICKS;
        end else if (dc_s2 && calls_ahead(any_v, Floor, !dir)) begin
          dir_nxt   = !dir;
          state_nxt = ST_MOVE;
          tmr_load  = 1'b1;
          tmr_val   = MOVE_TICKS;
        end
      end

      ST_MOVE: begin
        if (tmr_done) begin
          if (dir && Floor != 2'd3)       floor_nxt = Floor + 2'd1;
          else if (!dir && Floor != 2'd0) floor_nxt = Floor - 2'd1;
          // The shaft ends turn the sweep around.
          if (floor_nxt == 2'd3)      dir_nxt = 1'b0;
          else if (floor_nxt == 2'd0) dir_nxt = 1'b1;
          if (car_v[floor_nxt] || (dir ? up_v[floor_nxt] : dn_v[floor_nxt]) ||
              (!calls_ahead(any_v, floor_nxt, dir) && any_v[floor_nxt])) begin
            serve     = 1'b1;
            state_nxt = ST_OPEN_WAIT;
          end else begin
            tmr_load = 1'b1;
            tmr_val  = MOVE_TICKS;
          end
        end
      end

      ST_OPEN_WAIT: begin
        if (!dc_s2) begin
          state_nxt = ST_DWELL;
          tmr_load  = 1'b1;
          tmr_val   = DWELL_TICKS;
        end
      end

      ST_DWELL: begin
        if (tmr_done) begin
          state_nxt = ST_CLOSE_WAIT;
          tmr_load  = 1'b1;
          tmr_val   = CLOSE_TICKS;
        end
      end

      ST_CLOSE_WAIT: begin
        if (dc_s2) begin
          state_nxt = ST_IDLE;
        end else if (any_v[Floor]) begin
          serve     = 1'b1;
          state_nxt = ST_OPEN_WAIT;
        end else if (tmr_done) begin
          fault_nxt = 1'b1;
          state_nxt = ST_OPEN_WAIT;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase

    // When the only call here is a hall call against the sweep, adopt its
    // direction so it is actually cleared instead of reopening forever.
    if (serve) begin
      keep = car_v[floor_nxt] || (dir_nxt ? up_v[floor_nxt] : dn_v[floor_nxt]) ||
             !any_v[floor_nxt];
      if (!keep) dir_nxt = !dir_nxt;
      clr = serve_mask(floor_nxt, dir_nxt, !calls_ahead(any_v, floor_nxt, dir_nxt));
    end

    door_nxt = (state_nxt == ST_OPEN_WAIT) || (state_nxt == ST_DWELL);
    up_nxt   = (state_nxt == ST_MOVE) && dir_nxt;
    down_nxt = (state_nxt == ST_MOVE) && !dir_nxt;
  end

endmodule
`default_nettype wire

// File: tb/tb_elevator_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : tb_elevator_dispatch
// Purpose  : Directed self-checking bench for elevator_dispatch with a door
//            block model that follows Door three cycles late.
// Revision : 1.0 - initial release
// ============================================================================
module tb_elevator_dispatch;
  import elevator_pkg::*;

  localparam int MOVE_MS     = 20;
  localparam int DWELL_MS    = 30;
  localparam int CLOSE_TO_MS = 15;

  // Button masks in Req bit order
  localparam logic [9:0] M_B2U = 10'h002;
  localparam logic [9:0] M_B2D = 10'h004;
  localparam logic [9:0] M_B1U = 10'h001;
  localparam logic [9:0] M_B1  = 10'h040;
  localparam logic [9:0] M_B3  = 10'h100;
  localparam logic [9:0] M_B4  = 10'h200;

  logic       clk_1khz = 1'b0;
  logic       rst      = 1'b1;
  logic [9:0] btn      = '0;
  logic       hold     = 1'b0;
  logic [2:0] dly      = '0;
  logic       DoorClose;
  logic       Door, Up, Down, Fault;
  logic [1:0] Floor;
  logic [9:0] Req;

  int errors = 0;
  int checks = 0;
  int ups;
  int highs;

  always #5 clk_1khz = ~clk_1khz;

  // Door block: closed status follows the command three cycles late; hold jams it open.
  always @(posedge clk_1khz) dly <= {dly[1:0], Door};
  assign DoorClose = ~hold & ~dly[2];

  elevator_dispatch #(
    .MOVE_MS(MOVE_MS), .DWELL_MS(DWELL_MS), .CLOSE_TO_MS(CLOSE_TO_MS)
  ) dut (
    .clk_1khz (clk_1khz),
    .rst      (rst),
    .B1U      (btn[0]),
    .B2U      (btn[1]),
    .B2D      (btn[2]),
    .B3U      (btn[3]),
    .B3D      (btn[4]),
    .B4D      (btn[5]),
    .B1       (btn[6]),
    .B2       (btn[7]),
    .B3       (btn[8]),
    .B4       (btn[9]),
    .DoorClose(DoorClose),
    .Door     (Door),
    .Floor    (Floor),
    .Up       (Up),
    .Down     (Down),
    .Req      (Req),
    .Fault    (Fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_1khz);
  endtask

  task automatic press(input logic [9:0] m);
    btn = m;
    @(negedge clk_1khz);
    btn = '0;
  endtask

  task automatic wait_door(input logic v, input string tag);
    int n;
    n = 0;
    while (Door !== v && n < 400) begin
      @(negedge clk_1khz);
      n++;
    end
    chk(tag, 32'(Door), 32'(v));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_door"},  32'(Door),  32'd0);
    chk({tag, "_floor"}, 32'(Floor), 32'd0);
    chk({tag, "_up"},    32'(Up),    32'd0);
    chk({tag, "_down"},  32'(Down),  32'd0);
    chk({tag, "_req"},   32'(Req),   32'd0);
    chk({tag, "_fault"}, 32'(Fault), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    cyc(3);
    chk_reset("reset");
    rst = 1'b0;
    cyc(4);

    // Car call to floor 3 (index 2): 3-cycle latch latency, 40 cycles of Up
    press(M_B3);
    cyc(2);
    chk("req_latency", 32'(Req), 32'h100);
    chk("idle_no_up",  32'(Up),  32'd0);
    ups = 0;
    for (int i = 0; i < 200 && Door !== 1'b1; i++) begin
      @(negedge clk_1khz);
      if (Up === 1'b1) ups++;
    end
    chk("up_cycles",   32'(ups),   32'd40);
    chk("arrive_f2",   32'(Floor), 32'd2);
    chk("door_open",   32'(Door),  32'd1);
    chk("b3_cleared",  32'(Req),   32'd0);
    chk("up_dropped",  32'(Up),    32'd0);
    highs = 0;
    while (Door === 1'b1 && highs < 200) begin
      highs++;
      @(negedge clk_1khz);
    end
    chk("door_high_cycles", 32'(highs), 32'd36);
    cyc(10);
    chk("idle_f2_floor", 32'(Floor), 32'd2);
    chk("idle_f2_door",  32'(Door),  32'd0);
    chk("idle_f2_move",  32'({Up, Down}), 32'd0);

    // Back down to floor 0
    press(M_B1);
    cyc(5);
    chk("down_moving", 32'({Up, Down}), 32'd1);
    wait_door(1'b1, "open_f0");
    chk("arrive_f0", 32'(Floor), 32'd0);
    chk("b1_cleared", 32'(Req), 32'd0);
    wait_door(1'b0, "close_f0");
    cyc(10);

    // B4 then B2D from floor 0: floor 3 first, B2D served at floor 1 going down
    press(M_B4);
    cyc(2);
    press(M_B2D);
    wait_door(1'b1, "open_f3");
    chk("arrive_f3", 32'(Floor), 32'd3);
    chk("b2d_pending", 32'(Req), 32'h004);
    wait_door(1'b0, "close_f3");
    for (int i = 0; i < 100 && Down !== 1'b1; i++) @(negedge clk_1khz);
    chk("down_from_f3", 32'(Down), 32'd1);
    wait_door(1'b1, "open_f1");
    chk("arrive_f1", 32'(Floor), 32'd1);
    chk("b2d_cleared", 32'(Req), 32'd0);
    wait_door(1'b0, "close_f1");
    cyc(10);

    // Reopen from CLOSE_WAIT at floor 0 with the door block jammed open
    press(M_B1);
    wait_door(1'b1, "open_f0b");
    chk("arrive_f0b", 32'(Floor), 32'd0);
    hold = 1'b1;
    wait_door(1'b0, "close_wait_f0");
    press(M_B1U);
    cyc(2);
    chk("no_reopen_yet", 32'(Door), 32'd0);
    @(negedge clk_1khz);
    chk("reopen_door", 32'(Door), 32'd1);
    chk("b1u_cleared", 32'(Req), 32'd0);
    highs = 0;
    while (Door === 1'b1 && highs < 200) begin
      highs++;
      @(negedge clk_1khz);
    end
    chk("redwell_cycles", 32'(highs), 32'd31);

    // Close timeout: 15 cycles in CLOSE_WAIT with DoorClose held low
    cyc(14);
    chk("pre_timeout_fault", 32'(Fault), 32'd0);
    chk("pre_timeout_door",  32'(Door),  32'd0);
    @(negedge clk_1khz);
    chk("timeout_fault", 32'(Fault), 32'd1);
    chk("timeout_door",  32'(Door),  32'd1);
    hold = 1'b0;
    wait_door(1'b0, "close_after_fault");
    cyc(10);
    chk("fault_sticky", 32'(Fault), 32'd1);

    // Reset in the middle of a move at floor 2
    press(M_B4);
    for (int i = 0; i < 200 && Floor !== 2'd2; i++) @(negedge clk_1khz);
    chk("mid_move_floor", 32'(Floor), 32'd2);
    chk("mid_move_up",    32'(Up),    32'd1);
    rst = 1'b1;
    @(negedge clk_1khz);
    chk_reset("mid_rst");
    rst = 1'b0;
    cyc(4);

    // B2U and B2D together from floor 0: a single stop at floor 1 clears both
    press(M_B2U | M_B2D);
    wait_door(1'b1, "open_f1_both");
    chk("arrive_f1_both", 32'(Floor), 32'd1);
    chk("both_cleared",   32'(Req),   32'd0);
    wait_door(1'b0, "close_f1_both");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
